// File: rtl/fgyrus_win_loader.sv
// Windowed PCM loader for the Fusiform Gyrus FFT engine: reads PCM samples and window
// coefficients, multiplies, saturates and writes the real part into the FFT cache.
module fgyrus_win_loader #(
    parameter int NUM_CH         = 2,
    parameter int NUM_SAMPLES    = 128,
    parameter int SAMPLE_W       = 32,
    parameter int WIN_W          = 16,
    parameter int PCM_MEM_ADDR_W = 8,
    parameter int CACHE_ADDR_W   = 8,
    parameter int MEM_RD_DEL     = 2,
    parameter int MAX_OUTST      = 4,
    parameter int BIT_REV_EN     = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [NUM_CH-1:0]              ch_mask,
    input  logic                           abort,
    output logic                           busy,
    output logic                           done,
    output logic                           sat_flag,
    output logic                           err_flag,
    input  logic                           pcm_rdy,
    output logic [PCM_MEM_ADDR_W-1:0]      pcm_addr,
    output logic                           pcm_rden,
    input  logic [SAMPLE_W-1:0]            pcm_rdata,
    input  logic                           pcm_rd_valid,
    output logic [$clog2(NUM_SAMPLES)-1:0] win_ram_addr,
    output logic                           win_ram_rden,
    input  logic [WIN_W-1:0]               win_ram_rdata,
    output logic [CACHE_ADDR_W-1:0]        cache_addr,
    output logic [SAMPLE_W-1:0]            cache_wdata,
    output logic                           cache_wren
);

    localparam int LOG_NS = $clog2(NUM_SAMPLES);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int DEPTH  = 1 << PTR_W;
    localparam int CNT_W  = PTR_W + 1;
    localparam int PROD_W = SAMPLE_W + WIN_W + 1;

    localparam logic signed [PROD_W-1:0] SAT_MAX =
        {{(PROD_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN =
        {{(PROD_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    function automatic logic [LOG_NS-1:0] bit_rev(input logic [LOG_NS-1:0] v);
        logic [LOG_NS-1:0] r;
        for (int i = 0; i < LOG_NS; i++) r[i] = v[LOG_NS-1-i];
        return r;
    endfunction

    state_t              state_q;
    logic [NUM_CH-1:0]   mask_q;
    logic [CH_W-1:0]     ch_q;
    logic [LOG_NS-1:0]   n_q;
    logic                discard_q;
    logic [CNT_W-1:0]    outst_q;
    logic [MEM_RD_DEL-1:0] win_pipe_q;

    logic [WIN_W-1:0]        win_mem [DEPTH];
    logic [PTR_W-1:0]        win_wr_ptr_q, win_rd_ptr_q;
    logic [CNT_W-1:0]        win_cnt_q;
    logic [CACHE_ADDR_W-1:0] tgt_mem [DEPTH];
    logic [PTR_W-1:0]        tgt_wr_ptr_q, tgt_rd_ptr_q;

    logic                       mul_valid_q;
    logic signed [PROD_W-1:0]   mul_prod_q;
    logic [CACHE_ADDR_W-1:0]    mul_addr_q;

    logic [CH_W-1:0]          first_ch, nxt_ch;
    logic                     nxt_found;
    logic                     start_acc, issue, ret, cut, drained;
    logic                     win_ret, win_empty, win_hit, win_pop, win_push;
    logic [WIN_W-1:0]         win_coef;
    logic [CACHE_ADDR_W-1:0]  tgt_addr;
    logic signed [PROD_W-1:0] mul_a, mul_b, shifted;
    logic [SAMPLE_W-1:0]      sat_data;
    logic                     sat_hit;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        first_ch  = '0;
        nxt_ch    = '0;
        nxt_found = 1'b0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (ch_mask[c]) first_ch = CH_W'(c);
            if (mask_q[c] && (c > int'(ch_q))) begin
                nxt_found = 1'b1;
                nxt_ch    = CH_W'(c);
            end
        end
    end

    assign start_acc = (state_q == S_IDLE) && start;
    assign issue     = (state_q == S_ISSUE) && pcm_rdy && !abort
                       && (outst_q < CNT_W'(MAX_OUTST));
    // Returns with nothing outstanding (e.g. after a reset) are ignored entirely.
    assign ret       = pcm_rd_valid && (outst_q != '0);
    assign cut       = discard_q || abort;
    assign drained   = (outst_q == '0) && (win_pipe_q == '0);

    // A coefficient landing in the same cycle as its sample bypasses the FIFO.
    assign win_ret   = win_pipe_q[MEM_RD_DEL-1];
    assign win_empty = (win_cnt_q == '0);
    assign win_hit   = ret && (!win_empty || win_ret);
    assign win_pop   = ret && !win_empty;
    assign win_push  = win_ret && !(ret && win_empty) && (win_cnt_q != CNT_W'(DEPTH));
    assign win_coef  = win_empty ? win_ram_rdata : win_mem[win_rd_ptr_q];

    assign pcm_addr     = PCM_MEM_ADDR_W'({ch_q, n_q});
    assign pcm_rden     = issue;
    assign win_ram_addr = n_q;
    assign win_ram_rden = issue;
    assign tgt_addr     = CACHE_ADDR_W'({ch_q, (BIT_REV_EN != 0) ? bit_rev(n_q) : n_q});

    assign mul_a   = PROD_W'($signed(pcm_rdata));
    assign mul_b   = PROD_W'($signed({1'b0, win_coef}));
    assign shifted = mul_prod_q >>> (WIN_W - 1);

    always_comb begin
        sat_hit  = 1'b0;
        sat_data = shifted[SAMPLE_W-1:0];
        if (shifted > SAT_MAX) begin
            sat_hit  = 1'b1;
            sat_data = SAT_MAX[SAMPLE_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_hit  = 1'b1;
            sat_data = SAT_MIN[SAMPLE_W-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mask_q    <= '0;
            ch_q      <= '0;
            n_q       <= '0;
            discard_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        mask_q    <= ch_mask;
                        ch_q      <= first_ch;
                        n_q       <= '0;
                        discard_q <= 1'b0;
                        if (ch_mask == '0) begin
                            state_q <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (abort) begin
                        discard_q <= 1'b1;
                        state_q   <= S_DRAIN;
                    end else if (issue) begin
                        n_q <= n_q + 1'b1;
                        if (n_q == '1) begin
                            if (nxt_found) ch_q <= nxt_ch;
                            else           state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (abort) discard_q <= 1'b1;
                    if (drained) begin
                        if (cut) begin
                            state_q   <= S_IDLE;
                            busy      <= 1'b0;
                            discard_q <= 1'b0;
                        end else begin
                            state_q <= S_DONE;
                            done    <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst_q      <= '0;
            win_pipe_q   <= '0;
            win_wr_ptr_q <= '0;
            win_rd_ptr_q <= '0;
            win_cnt_q    <= '0;
            tgt_wr_ptr_q <= '0;
            tgt_rd_ptr_q <= '0;
        end else begin
            win_pipe_q <= (win_pipe_q << 1) | MEM_RD_DEL'(issue);
            case ({issue, ret})
                2'b10:   outst_q <= outst_q + 1'b1;
                2'b01:   outst_q <= outst_q - 1'b1;
                default: outst_q <= outst_q;
            endcase
            if (issue) tgt_wr_ptr_q <= tgt_wr_ptr_q + 1'b1;
            if (ret)   tgt_rd_ptr_q <= tgt_rd_ptr_q + 1'b1;
            if (start_acc) begin
                win_wr_ptr_q <= '0;
                win_rd_ptr_q <= '0;
                win_cnt_q    <= '0;
            end else begin
                if (win_push) win_wr_ptr_q <= win_wr_ptr_q + 1'b1;
                if (win_pop)  win_rd_ptr_q <= win_rd_ptr_q + 1'b1;
                case ({win_push, win_pop})
                    2'b10:   win_cnt_q <= win_cnt_q + 1'b1;
                    2'b01:   win_cnt_q <= win_cnt_q - 1'b1;
                    default: win_cnt_q <= win_cnt_q;
                endcase
            end
        end
    end

    // NOTE: FIFO storage has no reset; the pointers and counts alone define validity.
    always_ff @(posedge clk) begin
        if (win_push) win_mem[win_wr_ptr_q] <= win_ram_rdata;
        if (issue)    tgt_mem[tgt_wr_ptr_q] <= tgt_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_valid_q <= 1'b0;
            mul_prod_q  <= '0;
            mul_addr_q  <= '0;
            cache_wren  <= 1'b0;
            cache_addr  <= '0;
            cache_wdata <= '0;
            sat_flag    <= 1'b0;
            err_flag    <= 1'b0;
        end else begin
            mul_valid_q <= win_hit && !cut;
            if (win_hit) begin
                mul_prod_q <= mul_a * mul_b;
                mul_addr_q <= tgt_mem[tgt_rd_ptr_q];
            end
            cache_wren <= mul_valid_q && !cut;
            if (mul_valid_q) begin
                cache_addr  <= mul_addr_q;
                cache_wdata <= sat_data;
            end
            if (start_acc) begin
                sat_flag <= 1'b0;
                err_flag <= 1'b0;
            end else begin
                if (mul_valid_q && !cut && sat_hit) sat_flag <= 1'b1;
                if (ret && !win_hit)                err_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fgyrus_win_loader.sv
// Directed bench for fgyrus_win_loader with behavioural PCM buffer and window RAM models.
module tb_fgyrus_win_loader;

    localparam int NS  = 128;
    localparam int DEL = 2;
    localparam int MO  = 4;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [1:0]  ch_mask = 2'b00;
    logic        busy, done, sat_flag, err_flag;
    logic        pcm_rdy = 1'b1, pcm_rden, pcm_rd_valid = 1'b0;
    logic [7:0]  pcm_addr;
    logic [31:0] pcm_rdata = '0;
    logic [6:0]  win_ram_addr;
    logic        win_ram_rden;
    logic [15:0] win_ram_rdata = '0;
    logic [7:0]  cache_addr;
    logic [31:0] cache_wdata;
    logic        cache_wren;

    fgyrus_win_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ch_mask(ch_mask), .abort(abort),
        .busy(busy), .done(done), .sat_flag(sat_flag), .err_flag(err_flag),
        .pcm_rdy(pcm_rdy), .pcm_addr(pcm_addr), .pcm_rden(pcm_rden),
        .pcm_rdata(pcm_rdata), .pcm_rd_valid(pcm_rd_valid),
        .win_ram_addr(win_ram_addr), .win_ram_rden(win_ram_rden),
        .win_ram_rdata(win_ram_rdata), .cache_addr(cache_addr),
        .cache_wdata(cache_wdata), .cache_wren(cache_wren)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    pend_t       pq[$];
    pend_t       wq[$];
    logic [31:0] pcm_mem [256];
    logic [15:0] win_mem [NS];
    int          rd_addr_q[$];
    logic [7:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          cyc = 0, pcm_lat = 2, checks = 0, errors = 0;
    int          done_cnt, done_cyc, last_valid_cyc, tb_outst, max_outst;
    bit          rdy_toggle = 1'b0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Memory models: drive responses mid-cycle, then sample the DUT's strobes.
    initial forever begin
        @(negedge clk);
        pcm_rdy      = rdy_toggle ? ((cyc / 3) % 2 == 0) : 1'b1;
        pcm_rd_valid = 1'b0;
        if (pq.size() != 0 && pq[0].due == cyc) begin
            pcm_rd_valid   = 1'b1;
            pcm_rdata      = pq[0].data;
            last_valid_cyc = cyc;
            tb_outst       = tb_outst - 1;
            void'(pq.pop_front());
        end
        if (wq.size() != 0 && wq[0].due == cyc) begin
            win_ram_rdata = wq[0].data[15:0];
            void'(wq.pop_front());
        end
        #1;
        if (pcm_rden) begin
            pq.push_back('{cyc + pcm_lat, pcm_mem[pcm_addr]});
            rd_addr_q.push_back(int'(pcm_addr));
            tb_outst = tb_outst + 1;
        end
        if (win_ram_rden) wq.push_back('{cyc + DEL, {16'h0, win_mem[win_ram_addr]}});
        if (tb_outst > max_outst) max_outst = tb_outst;
        if (cache_wren) begin
            wr_addr_q.push_back(cache_addr);
            wr_data_q.push_back(cache_wdata);
            wr_cyc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed cycle %0d required < 100000", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] brev7(input int n);
        logic [6:0] v;
        logic [7:0] r;
        v = n[6:0];
        r = '0;
        for (int i = 0; i < 7; i++) r[i] = v[6-i];
        return r;
    endfunction

    task automatic clear_logs();
        rd_addr_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        done_cnt  = 0;
        done_cyc  = 0;
        tb_outst  = 0;
        max_outst = 0;
    endtask

    task automatic start_pulse(input logic [1:0] mask);
        @(negedge clk);
        ch_mask = mask;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, busy, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    // Checks k-th write against channel ch_base sample list with bit-reversed addressing.
    task automatic check_writes(input string tag, input int n_exp, input int scale_num,
                                input int scale_den);
        int bad = 0;
        check({tag, "_nwr"}, wr_data_q.size(), n_exp);
        for (int k = 0; k < wr_data_q.size() && k < n_exp; k++) begin
            int a;
            a = (rd_addr_q.size() > k) ? rd_addr_q[k] : -1;
            if (wr_addr_q[k] !== ((a / NS) * NS + brev7(a % NS))) bad++;
            if (a >= 0 && wr_data_q[k] !== 32'($signed(pcm_mem[a]) * scale_num / scale_den)) bad++;
        end
        check({tag, "_data"}, bad, 0);
    endtask

    initial begin
        int bad;
        int abort_cyc;
        int k;
        clear_logs();
        for (int i = 0; i < NS; i++) win_mem[i] = 16'h8000;
        for (int i = 0; i < 256; i++) pcm_mem[i] = 32'(i);

        // Reset state.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sat", sat_flag, 1'b0);
        check("rst_err", err_flag, 1'b0);
        check("rst_rden", pcm_rden, 1'b0);
        check("rst_wren", cache_wren, 1'b0);

        // Channel 0, window 1.0, pcm[n]=n: data n lands at bitrev7(n).
        clear_logs();
        start_pulse(2'b01);
        wait_idle("t1_idle", 1000);
        check("t1_nrd", rd_addr_q.size(), NS);
        bad = 0;
        for (int i = 0; i < wr_data_q.size() && i < NS; i++)
            if (wr_addr_q[i] !== brev7(i) || wr_data_q[i] !== 32'(i)) bad++;
        check("t1_nwr", wr_data_q.size(), NS);
        check("t1_data", bad, 0);
        check("t1_done_lat", done_cyc - last_valid_cyc, 2);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_sat", sat_flag, 1'b0);
        check("t1_err", err_flag, 1'b0);

        // Channel 1 only, window 0.5, pcm[128+n] = -2n -> -n.
        for (int i = 0; i < NS; i++) begin
            win_mem[i]      = 16'h4000;
            pcm_mem[NS + i] = 32'(-2 * i);
        end
        clear_logs();
        start_pulse(2'b10);
        wait_idle("t2_idle", 1000);
        bad = 0;
        for (int i = 0; i < rd_addr_q.size(); i++) if (rd_addr_q[i] != NS + i) bad++;
        check("t2_nrd", rd_addr_q.size(), NS);
        check("t2_addr", bad, 0);
        bad = 0;
        for (int i = 0; i < wr_data_q.size() && i < NS; i++)
            if (wr_addr_q[i] !== 8'(NS) + brev7(i) || wr_data_q[i] !== 32'(-i)) bad++;
        check("t2_nwr", wr_data_q.size(), NS);
        check("t2_data", bad, 0);

        // Positive saturation.
        for (int i = 0; i < NS; i++) begin
            win_mem[i] = 16'hFFFF;
            pcm_mem[i] = 32'h7FFF_FFFF;
        end
        clear_logs();
        start_pulse(2'b01);
        wait_idle("t3_idle", 1000);
        bad = 0;
        for (int i = 0; i < wr_data_q.size(); i++) if (wr_data_q[i] !== 32'h7FFF_FFFF) bad++;
        check("t3_nwr", wr_data_q.size(), NS);
        check("t3_sat_data", bad, 0);
        repeat (5) @(negedge clk);
        check("t3_sat_sticky", sat_flag, 1'b1);

        // Backpressure with slow returns over both channels.
        for (int i = 0; i < NS; i++) win_mem[i] = 16'h8000;
        for (int i = 0; i < 256; i++) pcm_mem[i] = 32'(3 * i + 7);
        rdy_toggle = 1'b1;
        pcm_lat    = 6;
        clear_logs();
        start_pulse(2'b11);
        check("t4_sat_cleared", sat_flag, 1'b0);
        wait_idle("t4_idle", 5000);
        bad = 0;
        for (int i = 0; i < rd_addr_q.size(); i++) if (rd_addr_q[i] != i) bad++;
        check("t4_rd_order", bad, 0);
        check_writes("t4", 256, 1, 1);
        check("t4_max_outst", max_outst <= MO, 1'b1);
        check("t4_err", err_flag, 1'b0);
        rdy_toggle = 1'b0;
        pcm_lat    = 2;

        // Abort after 40 issues.
        clear_logs();
        start_pulse(2'b11);
        k = 0;
        while (rd_addr_q.size() < 40 && k < 500) begin
            @(negedge clk);
            #2;
            k++;
        end
        @(negedge clk);
        abort     = 1'b1;
        abort_cyc = cyc;
        @(negedge clk);
        abort = 1'b0;
        wait_idle("t5_idle", 1000);
        bad = 0;
        for (int i = 0; i < wr_cyc_q.size(); i++) if (wr_cyc_q[i] > abort_cyc) bad++;
        check("t5_nrd", rd_addr_q.size(), 40);
        check("t5_wr_after_abort", bad, 0);
        check("t5_no_done", done_cnt, 0);
        check("t5_outst_drained", tb_outst, 0);

        // Normal run after abort; a second start while busy is ignored.
        clear_logs();
        start_pulse(2'b01);
        repeat (20) @(negedge clk);
        start_pulse(2'b10);
        wait_idle("t6_idle", 1000);
        bad = 0;
        for (int i = 0; i < rd_addr_q.size(); i++) if (rd_addr_q[i] >= NS) bad++;
        check("t6_ch0_only", bad, 0);
        check_writes("t6", NS, 1, 1);
        check("t6_done_cnt", done_cnt, 1);

        // Empty mask: done the next cycle, no memory access.
        clear_logs();
        start_pulse(2'b00);
        check("t7_done", done, 1'b1);
        @(negedge clk);
        check("t7_done_pulse", done, 1'b0);
        check("t7_busy", busy, 1'b0);
        check("t7_nrd", rd_addr_q.size(), 0);

        // PCM latency shorter than window latency flags an error.
        pcm_lat = 1;
        clear_logs();
        start_pulse(2'b01);
        wait_idle("t8_idle", 1000);
        check("t8_err", err_flag, 1'b1);
        pcm_lat = 2;

        // Asynchronous reset mid-load; late returns must be ignored.
        pcm_lat = 6;
        clear_logs();
        start_pulse(2'b01);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t9_busy", busy, 1'b0);
        check("t9_rden", pcm_rden, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        repeat (12) @(negedge clk);
        check("t9_nwr", wr_data_q.size(), 0);
        check("t9_err", err_flag, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
